// File: rtl/addr_seq_pkg.sv
// Shared definitions for the ROM address sequencer: direction encoding and
// the load-value clamp helper.
package addr_seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Operates on 16-bit values so any WIDTH up to 16 can share one helper.
  function automatic logic [15:0] clamp_load(input logic [15:0] val,
                                             input logic [15:0] limit);
    logic [15:0] res;
    if (val > limit) begin
      res = limit;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/offset_adder.sv
// WIDTH-bit ripple adder of full-adder cells with a constant OFFSET operand;
// the final carry out is intentionally not formed (address wraps modulo 2^WIDTH).
module offset_adder
  import addr_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int OFFSET = 2
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  localparam logic [WIDTH-1:0] OFF_V = WIDTH'(OFFSET);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = a[i] ^ OFF_V[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & OFF_V[i]) | (carry[i] & (a[i] ^ OFF_V[i]));
    end
  end

endmodule

// File: rtl/addr_sequencer.sv
// Modulo-(LIMIT+1) ROM address sequencer advancing on a vld/rdy handshake.
// Define ADDR_SEQ_DIR_EN to honour the dir input (down-counting).
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int OFFSET = 2,
  parameter int LIMIT  = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("addr_sequencer: WIDTH must be in 2..16");
  end
  if (LIMIT < 0 || LIMIT > (1 << WIDTH) - 1) begin : g_bad_limit
    $error("addr_sequencer: LIMIT must be in 0..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;
  logic             adv_s;

`ifndef ADDR_SEQ_DIR_EN
  logic unused_dir_s;
  assign unused_dir_s = dir;
`endif

  // Next count: load beats advance beats hold; wrap only on a wrapping advance.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    vld_d  = en;
    adv_s  = vld_q & rdy & en & ~load;
    if (load) begin
      cnt_d = WIDTH'(clamp_load(16'(load_val), 16'(LIMIT_V)));
    end else if (adv_s) begin
`ifdef ADDR_SEQ_DIR_EN
      if (dir == DIR_DOWN) begin
        if (cnt_q == ZERO_V) begin
          cnt_d  = LIMIT_V;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_V;
        end
      end else if (cnt_q == LIMIT_V) begin
        cnt_d  = ZERO_V;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE_V;
      end
`else
      if (cnt_q == LIMIT_V) begin
        cnt_d  = ZERO_V;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE_V;
      end
`endif
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= ZERO_V;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign vld  = vld_q;
  assign wrap = wrap_q;

  offset_adder #(
    .WIDTH  (WIDTH),
    .OFFSET (OFFSET)
  ) u_offset_adder (
    .a   (cnt_q),
    .sum (addr)
  );

endmodule

// File: tb/tb_addr_sequencer.sv
// Self-checking bench: two sequencer instances (OFFSET=2/LIMIT=9 and
// OFFSET=14/LIMIT=15) compared every cycle against a behavioural model.
module tb_addr_sequencer;

  localparam int OFF0 = 2;
  localparam int LIM0 = 9;
  localparam int OFF1 = 14;
  localparam int LIM1 = 15;
`ifdef ADDR_SEQ_DIR_EN
  localparam bit DIR_ON = 1'b1;
`else
  localparam bit DIR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load, dir, rdy;
  logic [3:0] load_val;
  logic       vld0, wrap0, vld1, wrap1;
  logic [3:0] addr0, cnt0, addr1, cnt1;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  int m_cnt [2];
  bit m_vld [2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  addr_sequencer #(.WIDTH(4), .OFFSET(OFF0), .LIMIT(LIM0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .rdy(rdy), .vld(vld0), .addr(addr0), .cnt(cnt0), .wrap(wrap0)
  );

  addr_sequencer #(.WIDTH(4), .OFFSET(OFF1), .LIMIT(LIM1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .rdy(rdy), .vld(vld1), .addr(addr1), .cnt(cnt1), .wrap(wrap1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_adv(bit vldv);
    return vldv && rdy && en && !load;
  endfunction

  function automatic int model_cnt(int c, int lim, bit vldv);
    if (load) return (int'(load_val) > lim) ? lim : int'(load_val);
    if (!model_adv(vldv)) return c;
    if (DIR_ON && dir) return (c + lim) % (lim + 1);
    return (c + 1) % (lim + 1);
  endfunction

  function automatic bit model_wrap(int c, int lim, bit vldv);
    if (load || !model_adv(vldv)) return 1'b0;
    if (DIR_ON && dir) return c == 0;
    return c == lim;
  endfunction

  // Reference model state update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  <= 0;
        m_vld[i]  <= 1'b0;
        m_wrap[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  <= model_cnt(m_cnt[i], (i == 0) ? LIM0 : LIM1, m_vld[i]);
        m_wrap[i] <= model_wrap(m_cnt[i], (i == 0) ? LIM0 : LIM1, m_vld[i]);
        m_vld[i]  <= en;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("vld0",  vld0,  32'(m_vld[0]));
      chk("cnt0",  cnt0,  32'(m_cnt[0]));
      chk("wrap0", wrap0, 32'(m_wrap[0]));
      chk("addr0", addr0, 32'((m_cnt[0] + OFF0) % 16));
      chk("vld1",  vld1,  32'(m_vld[1]));
      chk("cnt1",  cnt1,  32'(m_cnt[1]));
      chk("wrap1", wrap1, 32'(m_wrap[1]));
      chk("addr1", addr1, 32'((m_cnt[1] + OFF1) % 16));
    end
  end

  initial begin
    int got_addr[12];
    int exp_addr[12];
    int wraps;
    int n;

    exp_addr = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 2, 3};
    rst = 1'b0; en = 1'b0; load = 1'b0; dir = 1'b0; rdy = 1'b0; load_val = 4'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cnt",   cnt0,  32'd0);
    chk("rst_vld",   vld0,  32'd0);
    chk("rst_wrap",  wrap0, 32'd0);
    chk("rst_addr0", addr0, 32'd2);
    chk("rst_addr1", addr1, 32'd14);
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0; en = 1'b1; rdy = 1'b1;

    // Free-running sequence with a single wrap.
    wraps = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      got_addr[k] = int'(addr0);
      wraps += int'(wrap0);
    end
    for (int k = 0; k < 12; k++) chk($sformatf("seq_addr[%0d]", k), got_addr[k], exp_addr[k]);
    chk("seq_wrap_count", wraps, 1);

    // Stall at cnt=4.
    n = 0;
    while (m_cnt[0] != 4 && n < 30) begin @(negedge clk); #1; n++; end
    if (n >= 30) chk("stall_timeout", n, 0);
    #1 rdy = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_addr", addr0, 32'd6);
      chk("stall_vld",  vld0,  32'd1);
    end
    #1 rdy = 1'b1;
    @(negedge clk); #1;
    chk("resume_addr", addr0, 32'd7);

    // Clamped load, no advance on the load edge.
    #1 load = 1'b1; load_val = 4'd13;
    @(negedge clk); #1;
    chk("load_clamp_cnt",  cnt0,  32'd9);
    chk("load_clamp_wrap", wrap0, 32'd0);
    chk("load_noclamp_addr1", addr1, 32'd11);

    // Offset carry discarded on the OFFSET=14 instance.
    #1 load_val = 4'd3;
    @(negedge clk); #1;
    chk("carry_cnt1",  cnt1,  32'd3);
    chk("carry_addr1", addr1, 32'd1);
    #1 load = 1'b0;

`ifdef ADDR_SEQ_DIR_EN
    load = 1'b1; load_val = 4'd1;
    @(negedge clk); #1;
    #1 load = 1'b0; dir = 1'b1;
    @(negedge clk); #1;
    chk("down_cnt0",  cnt0,  32'd0);
    chk("down_addr0", addr0, 32'd2);
    @(negedge clk); #1;
    chk("down_cnt9",  cnt0,  32'd9);
    chk("down_addr11", addr0, 32'd11);
    chk("down_wrap",  wrap0, 32'd1);
    #1 dir = 1'b0;
`endif

    // Randomised traffic including rare asynchronous resets.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #2;
      en       = ($urandom_range(0, 9) != 0);
      rdy      = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom);
      dir      = 1'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
    end

    // Reset asserted mid-stream at cnt=5 acts without a clock edge.
    @(negedge clk); #2;
    rst = 1'b0; en = 1'b1; rdy = 1'b1; dir = 1'b0; load = 1'b1; load_val = 4'd0;
    @(negedge clk); #2 load = 1'b0;
    n = 0;
    while (m_cnt[0] != 5 && n < 30) begin @(negedge clk); #1; n++; end
    if (n >= 30) chk("midrst_timeout", n, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cnt",   cnt0,  32'd0);
    chk("midrst_vld",   vld0,  32'd0);
    chk("midrst_wrap",  wrap0, 32'd0);
    chk("midrst_addr0", addr0, 32'd2);
    chk("midrst_addr1", addr1, 32'd14);
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
